// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: address map, fetch FSM states and the
// entry format carried from fetch to decode.
package cpu_pkg;

    localparam logic [31:0] PC_BASE  = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush empties it on the edge and
// wins over a simultaneous push.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push;
    logic               do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // A push into a full FIFO is only accepted when a pop frees the slot.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    // NOTE: always_comb uses blocking assignments with a default first for every
    // output, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the head is masked to zero while
    // empty, so stale or unknown contents never reach decode.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, checks the fetch address against the ROM
// window, and queues {pc, instr, exc} entries for decode.
module fetch_ctrl #(
    parameter logic [31:0] PC_BASE  = cpu_pkg::PC_BASE,
    parameter int          IM_WORDS = cpu_pkg::IM_WORDS,
    parameter int          DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [31:0]             pcF,
    input  logic [31:0]             instrF,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [31:0]             d_pc,
    output logic [31:0]             d_instr,
    output logic                    d_exc,
    output logic [$clog2(DEPTH):0]  occupancy
);

    import cpu_pkg::*;

    localparam logic [31:0] LAST_PC = PC_BASE + 32'(4 * IM_WORDS) - 32'd4;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          bad;
    logic          deq;
    logic          space;
    logic          push;
    logic          flush;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign pcF   = pc_q;
    assign bad   = (pc_q[1:0] != 2'b00) | (pc_q < PC_BASE) | (pc_q > LAST_PC);
    assign deq   = d_valid & d_ready;
    assign space = ~fifo_full | deq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= PC_BASE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: if (!redirect && space && bad) state_d = FAULT;
            FAULT: if (redirect) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Redirect wins in either state; a faulting PC is queued once and then held.
    always_comb begin
        push       = 1'b0;
        flush      = 1'b0;
        pc_d       = pc_q;
        push_entry = '{pc: pc_q, instr: instrF, exc: 1'b0};
        if (redirect) begin
            flush = 1'b1;
            pc_d  = redirect_pc;
        end else if (state_q == FETCH && space) begin
            push = 1'b1;
            if (bad) begin
                push_entry.instr = NOP_WORD;
                push_entry.exc   = 1'b1;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (deq),
        .flush     (flush),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    assign d_valid = ~fifo_empty;
    assign d_pc    = head.pc;
    assign d_instr = head.instr;
    assign d_exc   = head.exc;

endmodule
